// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite command master: turns one register command at a time into a full
// AXI4-Lite transaction and returns a single response word, with a watchdog.
module axi_lite_cmd_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int STROBE_WIDTH   = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    i_cmd_valid,
    output logic                    o_cmd_ready,
    input  logic                    i_cmd_wr,
    input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
    input  logic [DATA_WIDTH-1:0]   i_cmd_data,
    input  logic [STROBE_WIDTH-1:0] i_cmd_strb,

    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [DATA_WIDTH-1:0]   o_rsp_data,
    output logic [1:0]              o_rsp_resp,
    output logic                    o_rsp_timeout,

    output logic                    o_awvalid,
    input  logic                    i_awready,
    output logic [ADDR_WIDTH-1:0]   o_awaddr,

    output logic                    o_wvalid,
    input  logic                    i_wready,
    output logic [STROBE_WIDTH-1:0] o_wstrb,
    output logic [DATA_WIDTH-1:0]   o_wdata,

    input  logic                    i_bvalid,
    output logic                    o_bready,
    input  logic [1:0]              i_bresp,

    output logic                    o_arvalid,
    input  logic                    i_arready,
    output logic [ADDR_WIDTH-1:0]   o_araddr,

    input  logic                    i_rvalid,
    output logic                    o_rready,
    input  logic [1:0]              i_rresp,
    input  logic [DATA_WIDTH-1:0]   i_rdata
);

    // The counter must hold TIMEOUT_CYCLES+1: an AR handshake may win on the
    // expiry cycle, leaving RD_DATA to start already past the limit.
    localparam int CNT_WIDTH = (TIMEOUT_CYCLES < 2) ? 2 : $clog2(TIMEOUT_CYCLES + 2);
    localparam int EXPIRE_AT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [CNT_WIDTH-1:0] EXPIRE_CNT   = CNT_WIDTH'(EXPIRE_AT);
    localparam logic                 TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [1:0]           RESP_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WR_RESP,
        READ,
        RD_DATA,
        RESPOND
    } state_t;

    typedef struct packed {
        logic                    cmd_ready;
        logic                    awvalid;
        logic [ADDR_WIDTH-1:0]   awaddr;
        logic                    wvalid;
        logic [STROBE_WIDTH-1:0] wstrb;
        logic [DATA_WIDTH-1:0]   wdata;
        logic                    bready;
        logic                    arvalid;
        logic [ADDR_WIDTH-1:0]   araddr;
        logic                    rready;
        logic                    rsp_valid;
        logic [DATA_WIDTH-1:0]   rsp_data;
        logic [1:0]              rsp_resp;
        logic                    rsp_timeout;
        logic [CNT_WIDTH-1:0]    cnt;
    } regs_t;

    state_t state, state_nxt;
    regs_t  r, r_nxt;
    logic   expired;
    logic   abort;

    // Expiry is judged on the count before this cycle's increment, so the
    // busy states last exactly TIMEOUT_CYCLES cycles without a handshake.
    assign expired = TIMEOUT_EN && (r.cnt >= EXPIRE_CNT);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before this edge.
        if (!rst) begin
            state <= IDLE;
            r     <= '0;
        end else begin
            state <= state_nxt;
            r     <= r_nxt;
        end
    end

    always_comb begin
        // NOTE: defaults first, so no path through the case can infer a latch.
        state_nxt = state;
        r_nxt     = r;
        abort     = 1'b0;

        if (state inside {WRITE, WR_RESP, READ, RD_DATA}) begin
            r_nxt.cnt = r.cnt + CNT_WIDTH'(1);
        end

        case (state)
            IDLE: begin
                r_nxt.cmd_ready = 1'b1;
                if (i_cmd_valid && r.cmd_ready) begin
                    r_nxt.cmd_ready = 1'b0;
                    r_nxt.cnt       = '0;
                    if (i_cmd_wr) begin
                        state_nxt     = WRITE;
                        r_nxt.awvalid = 1'b1;
                        r_nxt.awaddr  = i_cmd_addr;
                        r_nxt.wvalid  = 1'b1;
                        r_nxt.wdata   = i_cmd_data;
                        r_nxt.wstrb   = i_cmd_strb;
                    end else begin
                        state_nxt     = READ;
                        r_nxt.arvalid = 1'b1;
                        r_nxt.araddr  = i_cmd_addr;
                    end
                end
            end

            WRITE: begin
                // AW and W retire independently; B opens once both are gone.
                r_nxt.awvalid = r.awvalid && !i_awready;
                r_nxt.wvalid  = r.wvalid && !i_wready;
                if (!r_nxt.awvalid && !r_nxt.wvalid) begin
                    state_nxt    = WR_RESP;
                    r_nxt.bready = 1'b1;
                end else if (expired) begin
                    abort = 1'b1;
                end
            end

            WR_RESP: begin
                if (i_bvalid && r.bready) begin
                    state_nxt         = RESPOND;
                    r_nxt.bready      = 1'b0;
                    r_nxt.rsp_valid   = 1'b1;
                    r_nxt.rsp_data    = '0;
                    r_nxt.rsp_resp    = i_bresp;
                    r_nxt.rsp_timeout = 1'b0;
                end else if (expired) begin
                    abort = 1'b1;
                end
            end

            READ: begin
                if (r.arvalid && i_arready) begin
                    state_nxt     = RD_DATA;
                    r_nxt.arvalid = 1'b0;
                    r_nxt.rready  = 1'b1;
                end else if (expired) begin
                    abort = 1'b1;
                end
            end

            RD_DATA: begin
                if (i_rvalid && r.rready) begin
                    state_nxt         = RESPOND;
                    r_nxt.rready      = 1'b0;
                    r_nxt.rsp_valid   = 1'b1;
                    r_nxt.rsp_data    = i_rdata;
                    r_nxt.rsp_resp    = i_rresp;
                    r_nxt.rsp_timeout = 1'b0;
                end else if (expired) begin
                    abort = 1'b1;
                end
            end

            RESPOND: begin
                if (i_rsp_ready) begin
                    state_nxt       = IDLE;
                    r_nxt.rsp_valid = 1'b0;
                    r_nxt.cmd_ready = 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Watchdog abort: drop every AXI valid/ready so late beats are ignored.
        if (abort) begin
            state_nxt         = RESPOND;
            r_nxt.awvalid     = 1'b0;
            r_nxt.wvalid      = 1'b0;
            r_nxt.bready      = 1'b0;
            r_nxt.arvalid     = 1'b0;
            r_nxt.rready      = 1'b0;
            r_nxt.rsp_valid   = 1'b1;
            r_nxt.rsp_data    = '0;
            r_nxt.rsp_resp    = RESP_TIMEOUT;
            r_nxt.rsp_timeout = 1'b1;
        end
    end

    assign o_cmd_ready   = r.cmd_ready;
    assign o_rsp_valid   = r.rsp_valid;
    assign o_rsp_data    = r.rsp_data;
    assign o_rsp_resp    = r.rsp_resp;
    assign o_rsp_timeout = r.rsp_timeout;
    assign o_awvalid     = r.awvalid;
    assign o_awaddr      = r.awaddr;
    assign o_wvalid      = r.wvalid;
    assign o_wstrb       = r.wstrb;
    assign o_wdata       = r.wdata;
    assign o_bready      = r.bready;
    assign o_arvalid     = r.arvalid;
    assign o_araddr      = r.araddr;
    assign o_rready      = r.rready;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Self-checking bench for axi_lite_cmd_master: directed cases plus randomized
// commands against a memory-backed slave and a command-level reference model.
module tb_axi_lite_cmd_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_cmd_valid, o_cmd_ready, i_cmd_wr;
    logic [AW-1:0] i_cmd_addr;
    logic [DW-1:0] i_cmd_data;
    logic [SW-1:0] i_cmd_strb;
    logic          o_rsp_valid, i_rsp_ready, o_rsp_timeout;
    logic [DW-1:0] o_rsp_data;
    logic [1:0]    o_rsp_resp;
    logic          o_awvalid, i_awready;
    logic [AW-1:0] o_awaddr;
    logic          o_wvalid, i_wready;
    logic [SW-1:0] o_wstrb;
    logic [DW-1:0] o_wdata;
    logic          i_bvalid, o_bready;
    logic [1:0]    i_bresp;
    logic          o_arvalid, i_arready;
    logic [AW-1:0] o_araddr;
    logic          i_rvalid, o_rready;
    logic [1:0]    i_rresp;
    logic [DW-1:0] i_rdata;

    always #5 clk = ~clk;

    axi_lite_cmd_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STROBE_WIDTH(SW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_wr(i_cmd_wr),
        .i_cmd_addr(i_cmd_addr), .i_cmd_data(i_cmd_data), .i_cmd_strb(i_cmd_strb),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_data(o_rsp_data),
        .o_rsp_resp(o_rsp_resp), .o_rsp_timeout(o_rsp_timeout),
        .o_awvalid(o_awvalid), .i_awready(i_awready), .o_awaddr(o_awaddr),
        .o_wvalid(o_wvalid), .i_wready(i_wready), .o_wstrb(o_wstrb), .o_wdata(o_wdata),
        .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bresp(i_bresp),
        .o_arvalid(o_arvalid), .i_arready(i_arready), .o_araddr(o_araddr),
        .i_rvalid(i_rvalid), .o_rready(o_rready), .i_rresp(i_rresp), .i_rdata(i_rdata)
    );

    // Every output except o_cmd_ready, for "all zero" checks.
    logic others_nz;
    assign others_nz = |{o_rsp_valid, o_rsp_data, o_rsp_resp, o_rsp_timeout,
                         o_awvalid, o_awaddr, o_wvalid, o_wstrb, o_wdata, o_bready,
                         o_arvalid, o_araddr, o_rready};

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                            input logic [DW-1:0] new_v,
                                            input logic [SW-1:0] strb);
        logic [DW-1:0] v = old_v;
        for (int b = 0; b < SW; b++)
            if (strb[b]) v[8*b +: 8] = new_v[8*b +: 8];
        return v;
    endfunction

    // Slave behaviour knobs, set by the main thread before each command.
    int         aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    bit         hang_ar = 0, hang_b = 0;
    logic [1:0] s_bresp = 2'b00, s_rresp = 2'b00;

    logic [DW-1:0] slv_mem   [logic [AW-1:0]];
    logic [DW-1:0] model_mem [logic [AW-1:0]];

    function automatic logic [DW-1:0] slv_read(input logic [AW-1:0] a);
        return slv_mem.exists(a) ? slv_mem[a] : '0;
    endfunction

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        return model_mem.exists(a) ? model_mem[a] : '0;
    endfunction

    // Memory-backed AXI4-Lite slave; commits a write only when B completes.
    initial begin
        bit            got_aw, got_w, got_ar;
        int            aw_wait, w_wait, b_wait, ar_wait, r_wait;
        logic          p_awvalid, p_wvalid, p_bready, p_arvalid, p_rready;
        logic [AW-1:0] p_awaddr, p_araddr, s_awaddr, s_araddr;
        logic [DW-1:0] p_wdata, s_wdata;
        logic [SW-1:0] p_wstrb, s_wstrb;
        {i_awready, i_wready, i_bvalid, i_arready, i_rvalid} = '0;
        i_bresp = '0; i_rresp = '0; i_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                {got_aw, got_w, got_ar} = '0;
                {aw_wait, w_wait, b_wait, ar_wait, r_wait} = '0;
                {p_awvalid, p_wvalid, p_bready, p_arvalid, p_rready} = '0;
                {i_awready, i_wready, i_bvalid, i_arready, i_rvalid} = '0;
                continue;
            end
            // Handshakes completed at the preceding rising edge.
            if (i_awready && p_awvalid) begin got_aw = 1; s_awaddr = p_awaddr; end
            if (i_wready && p_wvalid) begin got_w = 1; s_wdata = p_wdata; s_wstrb = p_wstrb; end
            if (i_bvalid && p_bready) begin
                slv_mem[s_awaddr] = merge(slv_read(s_awaddr), s_wdata, s_wstrb);
                got_aw = 0; got_w = 0; b_wait = 0;
            end
            if (i_arready && p_arvalid) begin got_ar = 1; s_araddr = p_araddr; end
            if (i_rvalid && p_rready) begin got_ar = 0; r_wait = 0; end

            p_awvalid = o_awvalid; p_awaddr = o_awaddr;
            p_wvalid  = o_wvalid;  p_wdata  = o_wdata; p_wstrb = o_wstrb;
            p_bready  = o_bready;
            p_arvalid = o_arvalid; p_araddr = o_araddr;
            p_rready  = o_rready;

            i_awready = 0;
            if (o_awvalid && !got_aw) begin
                i_awready = (aw_wait >= aw_delay);
                aw_wait   = i_awready ? 0 : aw_wait + 1;
            end
            i_wready = 0;
            if (o_wvalid && !got_w) begin
                i_wready = (w_wait >= w_delay);
                w_wait   = i_wready ? 0 : w_wait + 1;
            end
            i_bvalid = 0;
            if (got_aw && got_w && !hang_b) begin
                i_bvalid = (b_wait >= b_delay);
                i_bresp  = s_bresp;
                b_wait++;
            end
            i_arready = 0;
            if (o_arvalid && !got_ar && !hang_ar) begin
                i_arready = (ar_wait >= ar_delay);
                ar_wait   = i_arready ? 0 : ar_wait + 1;
            end
            i_rvalid = 0;
            if (got_ar) begin
                i_rvalid = (r_wait >= r_delay);
                i_rdata  = slv_read(s_araddr);
                i_rresp  = s_rresp;
                r_wait++;
            end
        end
    end

    // Per-command bus observations.
    int            aw_n, w_n, ar_n, rsp_n, aw_first, w_first, w_last, ar_first, b_first;
    int            stab_viol = 0;
    logic [AW-1:0] mon_awaddr, mon_araddr;
    logic [DW-1:0] mon_wdata;
    logic [SW-1:0] mon_wstrb;

    task automatic clear_mon();
        aw_n = 0; w_n = 0; ar_n = 0; rsp_n = 0;
        aw_first = -1; w_first = -1; w_last = -1; ar_first = -1; b_first = -1;
    endtask

    initial begin
        logic          pv_aw = 0, pv_w = 0, pv_ar = 0, pv_rsp = 0;
        logic [AW-1:0] pv_awaddr = '0, pv_araddr = '0;
        logic [DW-1:0] pv_wdata = '0;
        logic [SW-1:0] pv_wstrb = '0;
        clear_mon();
        forever begin
            @(negedge clk);
            if (o_awvalid) begin
                if (aw_n == 0) begin aw_first = cyc; mon_awaddr = o_awaddr; end
                if (pv_aw && o_awaddr !== pv_awaddr) stab_viol++;
                aw_n++;
            end
            if (o_wvalid) begin
                if (w_n == 0) begin w_first = cyc; mon_wdata = o_wdata; mon_wstrb = o_wstrb; end
                if (pv_w && (o_wdata !== pv_wdata || o_wstrb !== pv_wstrb)) stab_viol++;
                w_n++;
                w_last = cyc;
            end
            if (o_arvalid) begin
                if (ar_n == 0) begin ar_first = cyc; mon_araddr = o_araddr; end
                if (pv_ar && o_araddr !== pv_araddr) stab_viol++;
                ar_n++;
            end
            if (o_bready && b_first < 0) b_first = cyc;
            if (o_rsp_valid && !pv_rsp) rsp_n++;
            pv_aw = o_awvalid; pv_awaddr = o_awaddr;
            pv_w  = o_wvalid;  pv_wdata  = o_wdata; pv_wstrb = o_wstrb;
            pv_ar = o_arvalid; pv_araddr = o_araddr;
            pv_rsp = o_rsp_valid;
        end
    end

    int acc_cyc;

    task automatic issue(input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [SW-1:0] strb, output bit ok);
        int n = 0;
        @(negedge clk);
        while (!o_cmd_ready && n < 50) begin @(negedge clk); n++; end
        ok = o_cmd_ready;
        if (!ok) begin
            check("cmd_ready_wait", o_cmd_ready, 1);
            return;
        end
        clear_mon();
        acc_cyc     = cyc;
        i_cmd_valid = 1; i_cmd_wr = wr; i_cmd_addr = addr; i_cmd_data = data; i_cmd_strb = strb;
        @(negedge clk);
        i_cmd_valid = 0;
    endtask

    // Waits for the response, holds it for `stall` cycles while offering a
    // competing command, then consumes it.
    task automatic get_rsp(input int stall, output logic [DW-1:0] d, output logic [1:0] r,
                           output logic t, output bit ok);
        int n = 0;
        int viol = 0;
        while (!o_rsp_valid && n < 100) begin @(negedge clk); n++; end
        ok = o_rsp_valid;
        if (!ok) begin
            check("rsp_wait", o_rsp_valid, 1);
            return;
        end
        d = o_rsp_data; r = o_rsp_resp; t = o_rsp_timeout;
        i_cmd_valid = (stall > 0);
        i_cmd_wr    = 1'($urandom_range(0, 1));
        i_cmd_addr  = 32'h40;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if (!o_rsp_valid || o_rsp_data !== d || o_rsp_resp !== r ||
                o_rsp_timeout !== t || o_cmd_ready) viol++;
        end
        i_cmd_valid = 0;
        i_rsp_ready = 1;
        @(negedge clk);
        i_rsp_ready = 0;
        if (stall > 0) check("rsp_hold", viol, 0);
    endtask

    task automatic run_txn(input string tag, input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input logic [SW-1:0] strb, input int stall);
        bit            ok;
        logic [DW-1:0] d, exp_d;
        logic [1:0]    r, exp_r;
        logic          t, exp_t;
        exp_t = wr ? hang_b : hang_ar;
        exp_r = exp_t ? 2'b11 : (wr ? s_bresp : s_rresp);
        exp_d = (wr || exp_t) ? '0 : model_read(addr);
        issue(wr, addr, data, strb, ok);
        if (!ok) return;
        get_rsp(stall, d, r, t, ok);
        if (!ok) return;
        check({tag, "_data"}, d, exp_d);
        check({tag, "_resp"}, r, exp_r);
        check({tag, "_timeout"}, t, exp_t);
        if (wr && !exp_t) model_mem[addr] = merge(model_read(addr), data, strb);
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: simulation did not finish, expected completion");
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        rst = 0;
        i_cmd_valid = 0; i_cmd_wr = 0; i_cmd_addr = '0; i_cmd_data = '0; i_cmd_strb = '0;
        i_rsp_ready = 0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", o_cmd_ready, 0);
        check("rst_outputs", others_nz, 0);
        rst = 1;
        @(negedge clk);
        check("cmd_ready_after_rst", o_cmd_ready, 1);
        check("idle_outputs", others_nz, 0);

        // Zero-wait write: AW and W together, one cycle each.
        run_txn("wr0", 1, 32'h4, 32'hDEAD_BEEF, 4'hF, 0);
        check("wr0_aw_cycles", aw_n, 1);
        check("wr0_w_cycles", w_n, 1);
        check("wr0_aw_first", aw_first, acc_cyc + 1);
        check("wr0_w_first", w_first, acc_cyc + 1);
        check("wr0_awaddr", mon_awaddr, 32'h4);
        check("wr0_wdata", mon_wdata, 32'hDEAD_BEEF);
        check("wr0_wstrb", mon_wstrb, 4'hF);

        run_txn("rd0", 0, 32'h4, '0, '0, 0);
        check("rd0_ar_cycles", ar_n, 1);
        check("rd0_araddr", mon_araddr, 32'h4);

        // W accepted five cycles after AW.
        w_delay = 5;
        run_txn("wr_wlate", 1, 32'h8, 32'h1234_5678, 4'b0101, 0);
        w_delay = 0;
        check("wlate_aw_cycles", aw_n, 1);
        check("wlate_w_cycles", w_n, 6);
        check("wlate_bready_after_w", b_first, w_last + 1);
        check("wlate_rsp_count", rsp_n, 1);

        s_rresp = 2'b10;
        run_txn("rd_slverr", 0, 32'hFFFF_FFF0, '0, '0, 0);
        s_rresp = 2'b00;

        // Slave never accepts AR: watchdog fires after TO cycles.
        hang_ar = 1;
        run_txn("rd_to", 0, 32'h4, '0, '0, 0);
        hang_ar = 0;
        check("rd_to_ar_cycles", ar_n, TO);
        check("rd_to_ar_first", ar_first, acc_cyc + 1);
        run_txn("rd_after_to", 0, 32'h4, '0, '0, 0);

        run_txn("stall", 0, 32'h8, '0, '0, 10);
        check("stall_rsp_dropped", o_rsp_valid, 0);
        check("stall_cmd_ready", o_cmd_ready, 1);
        check("stall_rsp_count", rsp_n, 1);

        // Reset while waiting for B: abandoned, no response.
        hang_b = 1;
        begin
            bit ok;
            issue(1, 32'h3C, 32'hCAFE_F00D, 4'hF, ok);
        end
        n = 0;
        while (!o_bready && n < 30) begin @(negedge clk); n++; end
        check("midrst_in_wr_resp", o_bready, 1);
        rst = 0;
        @(negedge clk);
        check("midrst_outputs", others_nz, 0);
        check("midrst_cmd_ready", o_cmd_ready, 0);
        @(negedge clk);
        rst = 1;
        hang_b = 0;
        @(negedge clk);
        check("midrst_cmd_ready_after", o_cmd_ready, 1);
        check("midrst_idle_outputs", others_nz, 0);
        repeat (TO + 4) @(negedge clk);
        check("midrst_no_rsp", rsp_n, 0);

        for (int i = 0; i < 40; i++) begin
            logic          wr;
            logic [AW-1:0] addr;
            aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
            b_delay  = $urandom_range(0, 3); ar_delay = $urandom_range(0, 3);
            r_delay  = $urandom_range(0, 3);
            s_bresp  = 2'($urandom_range(0, 3));
            s_rresp  = 2'($urandom_range(0, 3));
            wr       = 1'($urandom_range(0, 1));
            addr     = AW'($urandom_range(0, 15) * 4);
            run_txn("rnd", wr, addr, $urandom, SW'($urandom_range(0, 15)), $urandom_range(0, 3));
        end

        check("payload_stable", stab_viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_lite_cmd_master.md
Name: axi_lite_cmd_master

Overview:
- Upstream driver for AXI4-Lite slave peripherals such as the demo register block.
- Accepts one simple register command at a time: write or read, with address, data and strobe.
- Converts each command into a full AXI4-Lite transaction on the five channels, then returns a single response word with status.
- Includes a watchdog timeout so a hung slave cannot stall the command source forever.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI data width (32 or 64).
- STROBE_WIDTH, DATA_WIDTH/8, write strobe width.
- TIMEOUT_CYCLES, 256, cycles allowed from command accept to final AXI handshake; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- i_cmd_valid  in  1  command valid
- o_cmd_ready  out  1  command accepted when valid&ready
- i_cmd_wr  in  1  1=write, 0=read
- i_cmd_addr  in  ADDR_WIDTH  target address
- i_cmd_data  in  DATA_WIDTH  write data
- i_cmd_strb  in  STROBE_WIDTH  write strobes
- o_rsp_valid  out  1  response valid
- i_rsp_ready  in  1  response consumed when valid&ready
- o_rsp_data  out  DATA_WIDTH  read data (0 for writes)
- o_rsp_resp  out  2  BRESP/RRESP, or 2'b11 on timeout
- o_rsp_timeout  out  1  transaction aborted by watchdog
- o_awvalid out 1; i_awready in 1; o_awaddr out ADDR_WIDTH
- o_wvalid out 1; i_wready in 1; o_wstrb out STROBE_WIDTH; o_wdata out DATA_WIDTH
- i_bvalid in 1; o_bready out 1; i_bresp in 2
- o_arvalid out 1; i_arready in 1; o_araddr out ADDR_WIDTH
- i_rvalid in 1; o_rready out 1; i_rresp in 2; i_rdata in DATA_WIDTH

Behaviour:
- Reset (rst=0 at a clk edge):
  - State goes to IDLE.
  - All valid/ready outputs are 0, except o_cmd_ready, which is 1 from the first cycle after rst returns high.
  - All address, data and response outputs are 0; the timeout counter is 0.
  - Reset asserted mid-transaction abandons it immediately; no response is generated.
- All outputs are registered.
- States: IDLE, WRITE, WR_RESP, READ, RD_DATA, RESPOND.
- IDLE:
  - o_cmd_ready=1.
  - On handshake, latch addr/data/strb, clear the counter, and o_cmd_ready drops next cycle.
  - Write: go to WRITE, with o_awvalid=o_wvalid=1 the next cycle.
  - Read: go to READ, with o_arvalid=1 the next cycle.
- WRITE:
  - AW and W are independent; each valid holds until its own ready is sampled high, then clears the next cycle.
  - Once both have handshaken (same or different cycles), go to WR_RESP with o_bready=1.
  - Payloads stay stable while valid.
- WR_RESP: on i_bvalid&o_bready, capture i_bresp, set o_rsp_data=0, clear o_bready, go to RESPOND.
- READ: o_arvalid holds until i_arready; then clear it, set o_rready=1, go to RD_DATA.
- RD_DATA: on i_rvalid&o_rready, capture i_rdata and i_rresp, clear o_rready, go to RESPOND.
- RESPOND:
  - o_rsp_valid=1 with stable data/resp/timeout until i_rsp_ready; then go to IDLE with o_cmd_ready=1 the next cycle.
  - Minimum issue-to-issue spacing is therefore 4 cycles for a read against a zero-wait slave.
- Timeout:
  - The counter increments each cycle in WRITE/WR_RESP/READ/RD_DATA.
  - When it reaches TIMEOUT_CYCLES, all AXI valids/readies are forced to 0, and the block goes to RESPOND with o_rsp_resp=2'b11, o_rsp_timeout=1 and o_rsp_data=0.
  - A handshake in the same cycle as expiry wins; the timeout is not flagged.
- At most one transaction is outstanding; a late B/R beat arriving after a timeout is ignored, since bready/rready are 0.
- i_bresp/i_rresp are passed through unmodified; SLVERR (2'b10) is not a timeout.

Test Plan:
- Write addr=0x0000_0004, data=0xDEADBEEF, strb=4'hF, slave zero-wait -> AW and W asserted together one cycle after accept, each for 1 cycle, with addr/data/strb matching; o_rsp_valid with resp=2'b00, data=0, timeout=0.
- Read addr=0x4 after the previous write, slave returns 0xDEADBEEF -> o_arvalid for 1 cycle; o_rsp_data=0xDEADBEEF, resp=2'b00.
- Write with i_wready delayed 5 cycles after i_awready -> o_awvalid drops after its handshake, o_wvalid holds 5 extra cycles; o_bready asserts only after both handshakes; one response.
- Slave returns RRESP=2'b10 for addr=0xFFFF_FFF0 -> o_rsp_resp=2'b10, o_rsp_timeout=0.
- TIMEOUT_CYCLES=16, slave never asserts i_arready -> o_arvalid is held 16 cycles then drops; response has resp=2'b11, timeout=1, data=0; the next command is accepted normally.
- Reset pulled low while in WR_RESP, and o_rsp_valid stalled with i_rsp_ready=0 for 10 cycles in a separate run -> after reset all outputs are 0 and o_cmd_ready=1 the next cycle; in the stall run the response fields are stable for all 10 cycles and no new command is accepted.
